// File: rtl/hs32_execute.sv
// HS32 stage-3 execute: ALU, NZCV flags register and a single result register
// that feeds LSU/writeback and publishes forwarding/hazard info back to decode.

package hs32_pkg;

    typedef struct packed {
        logic [1:0] opr;   // 0 add, 1 and, 2 or, 3 xor
        logic       neg;   // invert operand B
        logic       sub;   // carry-in when cen is clear
        logic       cen;   // carry-in from the C flag
        logic       fwe;   // write NZCV
    } hs32_aluctl;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        we1;
        logic        we2;
        logic [3:0]  rd;
        logic [31:0] store;
        logic        xud;
        logic        isldr;
        logic        isstr;
        hs32_aluctl  ctl;
        logic [1:0]  fwd;
    } hs32_s2pkt;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        we1;
        logic        isldr;
        logic        isstr;
        logic        xud;
    } hs32_s3pkt;

    typedef struct packed {
        logic [3:0] rd;
        logic       vld;
        logic       lsu;
    } hs32_stall;

endpackage

module hs32_execute
    import hs32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  hs32_s2pkt   data_i,
    input  logic [31:0] fwd_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        valid_o,
    output hs32_s3pkt   data_o,
    output hs32_stall   s3_o,
    output logic [31:0] fwd_o,
    output logic [3:0]  flags_o
);

    // Handshake: an instruction is taken when valid_i && !stall_o && !flush_i;
    // a held result leaves when valid_q && !stall_i. Flush beats stall beats accept.

    logic        valid_q;
    logic [31:0] res_q;
    logic [3:0]  rd_q;
    logic        we1_q;
    logic        isldr_q;
    logic        isstr_q;
    logic        xud_q;
    logic [3:0]  flags_q;   // {N, Z, C, V}

    logic        accept;
    logic [31:0] opb;
    logic        cin;
    logic [32:0] sum;
    logic [31:0] alu_res;
    logic [3:0]  flags_nxt;

    // Decode's forwarding mux, store data and we2 are consumed elsewhere.
    logic unused_inputs;
    assign unused_inputs = ^{fwd_i, data_i.we2, data_i.store, data_i.fwd};

    assign stall_o = valid_q && stall_i;
    assign accept  = valid_i && !stall_o && !flush_i;

    always_comb begin
        opb     = data_i.ctl.neg ? ~data_i.d2 : data_i.d2;
        cin     = data_i.ctl.cen ? flags_q[1] : data_i.ctl.sub;
        sum     = {1'b0, data_i.d1} + {1'b0, opb} + {32'd0, cin};
        alu_res = sum[31:0];
        case (data_i.ctl.opr)
            2'd1:    alu_res = data_i.d1 & opb;
            2'd2:    alu_res = data_i.d1 | opb;
            2'd3:    alu_res = data_i.d1 ^ opb;
            default: alu_res = sum[31:0];
        endcase
    end

    // Logic ops keep C and V; only the adder produces carry and overflow.
    always_comb begin
        flags_nxt    = flags_q;
        flags_nxt[3] = alu_res[31];
        flags_nxt[2] = (alu_res == 32'd0);
        if (data_i.ctl.opr == 2'd0) begin
            flags_nxt[1] = sum[32];
            flags_nxt[0] = (data_i.d1[31] == opb[31]) && (sum[31] != data_i.d1[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            res_q   <= 32'd0;
            rd_q    <= 4'd0;
            we1_q   <= 1'b0;
            isldr_q <= 1'b0;
            isstr_q <= 1'b0;
            xud_q   <= 1'b0;
            flags_q <= 4'b0000;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            res_q   <= alu_res;
            rd_q    <= data_i.rd;
            we1_q   <= data_i.we1;
            isldr_q <= data_i.isldr;
            isstr_q <= data_i.isstr;
            xud_q   <= data_i.xud;
            if (data_i.ctl.fwe)
                flags_q <= flags_nxt;
        end else if (!stall_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o      = valid_q;
    assign data_o.res   = res_q;
    assign data_o.rd    = rd_q;
    assign data_o.we1   = we1_q && valid_q;
    assign data_o.isldr = isldr_q;
    assign data_o.isstr = isstr_q;
    assign data_o.xud   = xud_q;

    assign s3_o.rd  = rd_q;
    assign s3_o.vld = valid_q && we1_q;
    assign s3_o.lsu = isldr_q || isstr_q;

    assign fwd_o   = res_q;
    assign flags_o = flags_q;

endmodule

// File: tb/tb_hs32_execute.sv
// Directed bench for hs32_execute: ALU/flag vectors, ADC chaining, stall, flush, reset.

module tb_hs32_execute;
    import hs32_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_i;
    hs32_s2pkt   data_i;
    logic [31:0] fwd_i;
    logic        stall_i;
    logic        flush_i;
    logic        stall_o;
    logic        valid_o;
    hs32_s3pkt   data_o;
    hs32_stall   s3_o;
    logic [31:0] fwd_o;
    logic [3:0]  flags_o;

    int checks = 0;
    int failures = 0;

    hs32_execute dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .data_i  (data_i),
        .fwd_i   (fwd_i),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .s3_o    (s3_o),
        .fwd_o   (fwd_o),
        .flags_o (flags_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic hs32_s2pkt mk(input logic [31:0] d1, input logic [31:0] d2,
                                     input logic [1:0] opr, input logic neg,
                                     input logic sub, input logic cen, input logic fwe,
                                     input logic [3:0] rd, input logic isldr);
        hs32_s2pkt p;
        p           = '0;
        p.d1        = d1;
        p.d2        = d2;
        p.ctl.opr   = opr;
        p.ctl.neg   = neg;
        p.ctl.sub   = sub;
        p.ctl.cen   = cen;
        p.ctl.fwe   = fwe;
        p.rd        = rd;
        p.we1       = 1'b1;
        p.isldr     = isldr;
        p.store     = 32'hDEAD_BEEF;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: apply inputs, advance one edge, settle
    task automatic step(input logic v, input hs32_s2pkt p);
        valid_i = v;
        data_i  = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        valid_i = 1'b1;
        data_i  = mk(32'h1, 32'h2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        fwd_i   = 32'h5555_AAAA;
        stall_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_flags", {28'd0, flags_o}, 32'd0);
        check("rst_s3vld", {31'd0, s3_o.vld}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_res", data_o.res, 32'd0);
        reset = 1'b0;

        // add with carry-out and zero result
        step(1'b1, mk(32'hFFFF_FFFF, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
        check("add_res", data_o.res, 32'h0);
        check("add_flags", {28'd0, flags_o}, 32'b0110);
        check("add_valid", {31'd0, valid_o}, 32'd1);
        check("add_s3vld", {31'd0, s3_o.vld}, 32'd1);
        check("add_s3rd", {28'd0, s3_o.rd}, 32'd1);

        // signed overflow
        step(1'b1, mk(32'h7FFF_FFFF, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0));
        check("ovf_res", data_o.res, 32'h8000_0000);
        check("ovf_flags", {28'd0, flags_o}, 32'b1001);
        check("ovf_fwd", fwd_o, 32'h8000_0000);

        // SUB 5-7 then SBC 3-1 on consecutive edges
        step(1'b1, mk(32'h5, 32'h7, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0));
        check("sub_res", data_o.res, 32'hFFFF_FFFE);
        check("sub_flags", {28'd0, flags_o}, 32'b1000);
        step(1'b1, mk(32'h3, 32'h1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0));
        check("sbc_res", data_o.res, 32'h1);
        check("sbc_flags", {28'd0, flags_o}, 32'b0010);
        check("sbc_valid", {31'd0, valid_o}, 32'd1);

        // set C and V, then BIC must keep them
        step(1'b1, mk(32'h8000_0000, 32'h8000_0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0));
        check("cv_flags", {28'd0, flags_o}, 32'b0111);
        step(1'b1, mk(32'h0000_F0F0, 32'h0000_00FF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0));
        check("bic_res", data_o.res, 32'h0000_F000);
        check("bic_flags", {28'd0, flags_o}, 32'b0011);

        // OR without flag write, XOR to zero with flag write
        step(1'b1, mk(32'h0000_1200, 32'h0000_0034, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0));
        check("orr_res", data_o.res, 32'h0000_1234);
        check("orr_flags", {28'd0, flags_o}, 32'b0011);
        step(1'b1, mk(32'h0000_000F, 32'h0000_000F, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0));
        check("eor_res", data_o.res, 32'h0);
        check("eor_flags", {28'd0, flags_o}, 32'b0111);

        // held LDR under a 3-cycle stall; incoming packet must be ignored
        step(1'b1, mk(32'h0000_1000, 32'h0000_0020, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1));
        check("ldr_res", data_o.res, 32'h0000_1020);
        check("ldr_lsu", {31'd0, s3_o.lsu}, 32'd1);
        stall_i = 1'b1;
        #1;
        check("stall_comb", {31'd0, stall_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(32'hFFFF_FFFF, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0));
            check("stl_stall", {31'd0, stall_o}, 32'd1);
            check("stl_res", data_o.res, 32'h0000_1020);
            check("stl_rd", {28'd0, data_o.rd}, 32'd5);
            check("stl_lsu", {31'd0, s3_o.lsu}, 32'd1);
            check("stl_flags", {28'd0, flags_o}, 32'b0111);
        end

        // release with a new instruction: loaded on the same edge
        stall_i = 1'b0;
        step(1'b1, mk(32'h2, 32'h3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0));
        check("rel_res", data_o.res, 32'h5);
        check("rel_rd", {28'd0, data_o.rd}, 32'd7);
        check("rel_lsu", {31'd0, s3_o.lsu}, 32'd0);
        check("rel_flags", {28'd0, flags_o}, 32'b0000);
        check("rel_valid", {31'd0, valid_o}, 32'd1);

        // flush blocks incoming instruction and its flag write
        flush_i = 1'b1;
        step(1'b1, mk(32'hFFFF_FFFF, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0));
        flush_i = 1'b0;
        check("fl_valid", {31'd0, valid_o}, 32'd0);
        check("fl_flags", {28'd0, flags_o}, 32'b0000);
        check("fl_s3vld", {31'd0, s3_o.vld}, 32'd0);
        check("fl_we1", {31'd0, data_o.we1}, 32'd0);

        // drain with no new instruction
        step(1'b1, mk(32'h10, 32'h20, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0));
        check("ld_res", data_o.res, 32'h30);
        step(1'b0, mk(32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
        check("drain_valid", {31'd0, valid_o}, 32'd0);

        // reset during a stall discards the held result
        step(1'b1, mk(32'h7FFF_FFFF, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0));
        check("pre_flags", {28'd0, flags_o}, 32'b1001);
        stall_i = 1'b1;
        reset   = 1'b1;
        step(1'b1, mk(32'h1, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0));
        reset   = 1'b0;
        check("rs_valid", {31'd0, valid_o}, 32'd0);
        check("rs_flags", {28'd0, flags_o}, 32'd0);
        check("rs_res", data_o.res, 32'd0);
        check("rs_stall", {31'd0, stall_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs32_execute.md
# hs32_execute

Stage-3 execute unit of the HS32 pipeline: consumes the `hs32_s2pkt` produced by stage-2 decode, performs the ALU operation selected by its `hs32_aluctl` bundle, and holds the result in a single pipeline register for the LSU/writeback stage. It owns the architectural NZCV flags register. It publishes the `hs32_stall` hazard descriptor and forwarding value that decode uses to forward results or stall. Store-data sourcing and memory access are out of scope; they belong to the LSU.

## Interface

No parameters.

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `valid_i`  in  1  `data_i` holds a valid instruction
- `data_i`  in  `hs32_s2pkt`  `d1`, `d2`, `we1`, `we2`, `rd`, `store`, `xud`, `isldr`, `isstr`, `ctl`, `fwd`
- `fwd_i`  in  32  not used in this block; forwarding mux lives in decode
- `stall_i`  in  1  downstream (LSU/writeback) cannot accept the held result this cycle
- `flush_i`  in  1  kill the held result and block the incoming instruction
- `stall_o`  out  1  execute cannot accept `data_i` this cycle
- `valid_o`  out  1  `data_o` valid
- `data_o`  out  `hs32_s3pkt`  `res[31:0]`, `rd[3:0]`, `we1`, `isldr`, `isstr`, `xud`
- `s3_o`  out  `hs32_stall`  hazard descriptor `{rd, vld, lsu}` for decode
- `fwd_o`  out  32  forwarding value (`res` of the held result)
- `flags_o`  out  4  `{N,Z,C,V}`

## Operation

- Accept condition: `valid_i && !stall_o && !flush_i`.
- `stall_o = valid_q && stall_i`.
- ALU datapath, 33-bit adder:
  - Adder operand B is `~d2` when `ctl.neg` is set, otherwise `d2`.
  - Carry-in is `C` when `ctl.cen` is set. Otherwise it is `ctl.sub`.
  - `cen` and `sub` together give subtract-with-carry, which uses the `C` flag.
- Operation select by `ctl.opr`:
  - `0`: `res = d1 + B + cin`
  - `1`: `res = d1 & B` (BIC arises from `neg` with `opr=1`)
  - `2`: `res = d1 | B`
  - `3`: `res = d1 ^ B`
- Mov and LSU instructions arrive as add with `d1=0` or as base+offset; no special-casing here.
- Flag update happens only on accept with `ctl.fwe=1`:
  - `N = res[31]` and `Z = (res==0)` for every operation.
  - Add (`opr=0`) also updates `C = carry-out[32]`, where 1 means no borrow on subtract.
  - Add also updates `V = (A[31]==B[31]) && (res[31]!=A[31])`, with B after inversion.
  - Logic operations preserve `C` and `V`.
- The flag computation uses `cin` from the flags register value before the update, so back-to-back ADC chains are correct with no bubble.
- Pipeline register contents:
  - On accept: `res`, `rd`, `we1`, `isldr`, `isstr`, `xud` are loaded and `valid_q` is set to 1.
  - When `valid_q && !stall_i` and there is no accept: `valid_q` is set to 0.
  - When `stall_i` is high: everything holds.
- `s3_o.rd = rd_q`.
- `s3_o.vld = valid_q && we1_q`.
- `s3_o.lsu = isldr_q || isstr_q`.
- `fwd_o = res_q`, driven unconditionally.
- `valid_o = valid_q`.
- `data_o.we1` is qualified by `valid_q`. `we2` is unused and tied 0 downstream.

## Timing

- Latency: an instruction accepted at edge N appears on `data_o`, `fwd_o` and `s3_o` after edge N; flags are updated at the same edge.
- A dependent instruction can therefore forward on the following cycle.
- Throughput: one instruction per cycle when `stall_i` is low.
- Reset outputs, applied at the first edge with `reset` high: `valid_q=0`, `res_q=0`, `rd_q=0`, `we1_q=0`, `isldr_q=0`, `isstr_q=0`, `xud_q=0`, `flags=4'b0000`. As a result `stall_o=0` and `s3_o.vld=0`.
- Reset mid-stall overrides everything, and the held result is discarded.
- `flush_i` priority: flush over `stall_i` over accept.
  - Flush sets `valid_q=0` next cycle.
  - Under flush, flags are not written by the incoming instruction.
  - Under flush, `res_q`/`rd_q` may hold stale values.
- Simultaneous drain and accept (`valid_q && !stall_i && valid_i`): the new instruction replaces the old one in the same edge, with no bubble.
- While stalled, `data_i` is ignored and the flags are frozen; decode must hold its packet.
- Adder wrap: `0xFFFFFFFF + 1` gives `res=0` with C=1; there are no other width extensions.

## Test plan

- **Reset:** assert `reset` for 2 cycles with `valid_i=1` → `valid_o=0`, `flags_o=0`, `s3_o.vld=0`, `stall_o=0`.
- **Add carry/zero:** add `d1=0xFFFFFFFF`, `d2=1`, `fwe=1` → next cycle `res=0`, flags `{N,Z,C,V}=0110`.
- **Signed overflow:** add `0x7FFFFFFF+1` → `res=0x80000000`, flags `1001`.
- **SUB then SBC chain:**
  - `SUB` `5-7` (`neg=1`, `sub=1`) → `res=0xFFFFFFFE`, C=0.
  - Next cycle `SBC` `3-1` (`neg=1`, `sub=1`, `cen=1`, using C=0) → `res=1`, C=1.
  - No bubble between the two.
- **BIC preserves C/V:** set C=1 first, then `opr=1`, `neg=1`, `d1=0xF0F0`, `d2=0x00FF` → `res=0xF000`, flags N=0, Z=0, C=1, V held.
- **Stall/flush:**
  - Hold `stall_i=1` for 3 cycles with a held LDR → `stall_o=1`, `data_o` stable, `s3_o.lsu=1`, flags frozen.
  - Release with a new valid instruction → the new one is loaded at that edge.
  - Assert `flush_i` → `valid_o=0` next cycle, flags unchanged.
